// File: rtl/writeback_unit_pkg.sv
// Shared definitions for the writeback stage: datapath width, write-source
// and load-type encodings, and the controller state type.
package writeback_unit_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] WB_SRC_ALU  = 2'b00;
    localparam logic [1:0] WB_SRC_LOAD = 2'b01;
    localparam logic [1:0] WB_SRC_PC4  = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_WAIT_LOAD = 2'b01,
        ST_WRITE     = 2'b10
    } wb_state_t;

endpackage

// File: rtl/writeback_unit_load_extract.sv
// Combinational load alignment: picks the byte/half/word out of the memory
// word, sign/zero-extends it, and flags misaligned or unknown load types.
module writeback_unit_load_extract
    import writeback_unit_pkg::*;
(
    input  logic [2:0]      i_funct3,
    input  logic [1:0]      i_addr,
    input  logic [XLEN-1:0] i_mem_rdata,
    output logic [XLEN-1:0] o_data,
    output logic            o_err
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_mem_rdata[{i_addr, 3'b000} +: 8];
    assign w_half = i_mem_rdata[{i_addr[1], 4'b0000} +: 16];

    always_comb begin
        o_data = i_mem_rdata;
        o_err  = 1'b0;
        case (i_funct3)
            F3_LB:  o_data = {{24{w_byte[7]}}, w_byte};
            F3_LBU: o_data = {24'd0, w_byte};
            F3_LH: begin
                o_data = {{16{w_half[15]}}, w_half};
                o_err  = i_addr[0];
            end
            F3_LHU: begin
                o_data = {16'd0, w_half};
                o_err  = i_addr[0];
            end
            F3_LW:  o_err = (i_addr != 2'b00);
            default: o_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: accepts one retired result per handshake, waits for load
// data when needed, and issues a one-cycle register-file write pulse.
module writeback_unit
    import writeback_unit_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wb_valid,
    output logic            wb_ready,
    input  logic [4:0]      rdsel_in,
    input  logic            rd_we,
    input  logic [1:0]      wb_src,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] pc,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [XLEN-1:0] rddata_wr,
    output logic [4:0]      rdsel_wr,
    output logic            phase_writeback,
    output logic            retire,
    output logic            load_err
);

    wb_state_t       r_state;
    logic [4:0]      r_rdsel;
    logic            r_rd_we;
    logic [2:0]      r_funct3;
    logic [1:0]      r_addr;
    logic [XLEN-1:0] r_rddata_wr;
    logic [4:0]      r_rdsel_wr;
    logic            r_phase_wb;
    logic            r_retire;
    logic            r_load_err;

    logic            w_idle;
    logic            w_accept;
    logic            w_is_load;
    logic            w_rd_writes;
    logic [XLEN-1:0] w_value;
    logic [2:0]      w_ex_funct3;
    logic [1:0]      w_ex_addr;
    logic [XLEN-1:0] w_ex_data;
    logic            w_ex_err;

    assign w_idle      = (r_state == ST_IDLE);
    assign w_accept    = wb_valid & w_idle;
    assign w_is_load   = (wb_src == WB_SRC_LOAD);
    assign w_rd_writes = rd_we & (rdsel_in != 5'd0);
    assign w_value     = (wb_src == WB_SRC_PC4) ? pc + 32'd4 : alu_result;

    // One extractor serves both phases: live inputs for the alignment check
    // at acceptance, latched type/offset once waiting on the memory response.
    assign w_ex_funct3 = w_idle ? funct3 : r_funct3;
    assign w_ex_addr   = w_idle ? alu_result[1:0] : r_addr;

    writeback_unit_load_extract u_load_extract (
        .i_funct3    (w_ex_funct3),
        .i_addr      (w_ex_addr),
        .i_mem_rdata (mem_rdata),
        .o_data      (w_ex_data),
        .o_err       (w_ex_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_rdsel     <= 5'd0;
            r_rd_we     <= 1'b0;
            r_funct3    <= 3'd0;
            r_addr      <= 2'd0;
            r_rddata_wr <= '0;
            r_rdsel_wr  <= 5'd0;
            r_phase_wb  <= 1'b0;
            r_retire    <= 1'b0;
            r_load_err  <= 1'b0;
        end else begin
            r_phase_wb <= 1'b0;
            r_retire   <= 1'b0;
            r_load_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_rdsel  <= rdsel_in;
                        r_rd_we  <= rd_we;
                        r_funct3 <= funct3;
                        r_addr   <= alu_result[1:0];
                        if (!w_is_load) begin
                            r_state    <= ST_WRITE;
                            r_retire   <= 1'b1;
                            r_phase_wb <= w_rd_writes;
                            if (w_rd_writes) begin
                                r_rddata_wr <= w_value;
                                r_rdsel_wr  <= rdsel_in;
                            end
                        end else if (w_ex_err) begin
                            r_state    <= ST_WRITE;
                            r_retire   <= 1'b1;
                            r_load_err <= 1'b1;
                        end else begin
                            r_state <= ST_WAIT_LOAD;
                        end
                    end
                end
                ST_WAIT_LOAD: begin
                    if (mem_rvalid) begin
                        r_state    <= ST_WRITE;
                        r_retire   <= 1'b1;
                        r_phase_wb <= r_rd_we & (r_rdsel != 5'd0);
                        if (r_rd_we && (r_rdsel != 5'd0)) begin
                            r_rddata_wr <= w_ex_data;
                            r_rdsel_wr  <= r_rdsel;
                        end
                    end
                end
                ST_WRITE: r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    assign wb_ready        = w_idle;
    assign rddata_wr       = r_rddata_wr;
    assign rdsel_wr        = r_rdsel_wr;
    assign phase_writeback = r_phase_wb;
    assign retire          = r_retire;
    assign load_err        = r_load_err;

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed vector table, randomized
// transactions against a reference model, and a reset-during-load sequence.
module tb_writeback_unit;

    logic        clk;
    logic        rst_n;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  rdsel_in;
    logic        rd_we;
    logic [1:0]  wb_src;
    logic [2:0]  funct3;
    logic [31:0] alu_result;
    logic [31:0] pc;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [31:0] rddata_wr;
    logic [4:0]  rdsel_wr;
    logic        phase_writeback;
    logic        retire;
    logic        load_err;

    int n_checks = 0;
    int n_pass   = 0;

    writeback_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .wb_valid        (wb_valid),
        .wb_ready        (wb_ready),
        .rdsel_in        (rdsel_in),
        .rd_we           (rd_we),
        .wb_src          (wb_src),
        .funct3          (funct3),
        .alu_result      (alu_result),
        .pc              (pc),
        .mem_rvalid      (mem_rvalid),
        .mem_rdata       (mem_rdata),
        .rddata_wr       (rddata_wr),
        .rdsel_wr        (rdsel_wr),
        .phase_writeback (phase_writeback),
        .retire          (retire),
        .load_err        (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  src;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] alu;
        logic [31:0] pc;
        logic [31:0] rdata;
        int          dly;
        logic        exp_wr;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Reference behaviour written directly from the load/writeback rules.
    function automatic void model(input vec_t v, output logic wr, output logic [31:0] data,
                                  output logic err);
        int unsigned a;
        logic [31:0] b;
        logic [31:0] h;
        a    = v.alu % 4;
        err  = 1'b0;
        data = 32'd0;
        if (v.src == 2'b01) begin
            b = (v.rdata >> (8 * a)) & 32'hFF;
            h = (v.rdata >> (16 * (a / 2))) & 32'hFFFF;
            case (v.f3)
                3'b000: data = (b >= 128) ? b - 32'd256 : b;
                3'b100: data = b;
                3'b001: begin err = (a % 2) != 0; data = (h >= 32768) ? h - 32'd65536 : h; end
                3'b101: begin err = (a % 2) != 0; data = h; end
                3'b010: begin err = (a != 0); data = v.rdata; end
                default: err = 1'b1;
            endcase
        end else if (v.src == 2'b10) begin
            data = v.pc + 32'd4;
        end else begin
            data = v.alu;
        end
        wr = v.we && (v.rd != 5'd0) && !err;
    endfunction

    task automatic run_txn(input vec_t v, input string tag);
        @(negedge clk);
        chk({tag, ".ready_at_accept"}, {31'd0, wb_ready}, 32'd1);
        wb_valid   = 1'b1;
        wb_src     = v.src;
        funct3     = v.f3;
        rdsel_in   = v.rd;
        rd_we      = v.we;
        alu_result = v.alu;
        pc         = v.pc;
        mem_rvalid = 1'b1;          // stale response while idle must be ignored
        mem_rdata  = ~v.rdata;
        @(negedge clk);
        wb_valid   = 1'b0;
        mem_rvalid = 1'b0;
        funct3     = 3'($urandom);
        rdsel_in   = 5'($urandom);
        rd_we      = 1'($urandom);
        alu_result = $urandom;
        pc         = $urandom;
        if (v.src == 2'b01 && !v.exp_err) begin
            for (int i = 0; i < v.dly; i++) begin
                chk({tag, ".ready_wait"}, {31'd0, wb_ready}, 32'd0);
                chk({tag, ".wb_wait"}, {31'd0, phase_writeback}, 32'd0);
                @(negedge clk);
            end
            mem_rvalid = 1'b1;
            mem_rdata  = v.rdata;
            @(negedge clk);
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
        end
        chk({tag, ".phase_wb"}, {31'd0, phase_writeback}, {31'd0, v.exp_wr});
        chk({tag, ".retire"}, {31'd0, retire}, 32'd1);
        chk({tag, ".load_err"}, {31'd0, load_err}, {31'd0, v.exp_err});
        if (v.exp_wr) begin
            chk({tag, ".rdsel_wr"}, {27'd0, rdsel_wr}, {27'd0, v.rd});
            chk({tag, ".rddata_wr"}, rddata_wr, v.exp_data);
        end
        $display("txn %s src=%0d f3=%0d rd=%0d we=%0b addr=%08h -> wr=%0b data=%08h err=%0b",
                 tag, v.src, v.f3, v.rd, v.we, v.alu, phase_writeback, rddata_wr, load_err);
        @(negedge clk);
        chk({tag, ".phase_wb_drop"}, {31'd0, phase_writeback}, 32'd0);
        chk({tag, ".retire_drop"}, {31'd0, retire}, 32'd0);
        chk({tag, ".ready_after"}, {31'd0, wb_ready}, 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t rv;
        rst_n = 1'b0; wb_valid = 1'b0; rdsel_in = 5'd0; rd_we = 1'b0; wb_src = 2'b00;
        funct3 = 3'd0; alu_result = 32'd0; pc = 32'd0; mem_rvalid = 1'b0; mem_rdata = 32'd0;

        //           src    f3      rd     we    alu            pc             rdata         dly wr    data           err
        vecs[0]  = '{2'b00, 3'b000, 5'd5,  1'b1, 32'h1234_5678, 32'h0,         32'h0,         0, 1'b1, 32'h1234_5678, 1'b0};
        vecs[1]  = '{2'b10, 3'b000, 5'd1,  1'b1, 32'h0,         32'hFFFF_FFFC, 32'h0,         0, 1'b1, 32'h0000_0000, 1'b0};
        vecs[2]  = '{2'b01, 3'b000, 5'd10, 1'b1, 32'h0000_0103, 32'h0,         32'h80AA_BBCC, 3, 1'b1, 32'hFFFF_FF80, 1'b0};
        vecs[3]  = '{2'b01, 3'b100, 5'd11, 1'b1, 32'h0000_0103, 32'h0,         32'h80AA_BBCC, 3, 1'b1, 32'h0000_0080, 1'b0};
        vecs[4]  = '{2'b01, 3'b101, 5'd12, 1'b1, 32'h0000_0102, 32'h0,         32'h80AA_BBCC, 3, 1'b1, 32'h0000_80AA, 1'b0};
        vecs[5]  = '{2'b01, 3'b010, 5'd13, 1'b1, 32'h0000_0101, 32'h0,         32'h0,         0, 1'b0, 32'h0,         1'b1};
        vecs[6]  = '{2'b01, 3'b001, 5'd14, 1'b1, 32'h0000_0003, 32'h0,         32'h0,         0, 1'b0, 32'h0,         1'b1};
        vecs[7]  = '{2'b01, 3'b011, 5'd15, 1'b1, 32'h0000_0100, 32'h0,         32'h0,         0, 1'b0, 32'h0,         1'b1};
        vecs[8]  = '{2'b00, 3'b000, 5'd0,  1'b1, 32'hDEAD_BEEF, 32'h0,         32'h0,         0, 1'b0, 32'h0,         1'b0};
        vecs[9]  = '{2'b00, 3'b000, 5'd7,  1'b0, 32'hDEAD_BEEF, 32'h0,         32'h0,         0, 1'b0, 32'h0,         1'b0};
        vecs[10] = '{2'b11, 3'b000, 5'd3,  1'b1, 32'hCAFE_F00D, 32'h0,         32'h0,         0, 1'b1, 32'hCAFE_F00D, 1'b0};
        vecs[11] = '{2'b01, 3'b001, 5'd12, 1'b1, 32'h0000_0102, 32'h0,         32'h80AA_BBCC, 2, 1'b1, 32'hFFFF_80AA, 1'b0};
        vecs[12] = '{2'b01, 3'b010, 5'd31, 1'b1, 32'h0000_0200, 32'h0,         32'h1357_9BDF, 0, 1'b1, 32'h1357_9BDF, 1'b0};
        vecs[13] = '{2'b01, 3'b000, 5'd4,  1'b1, 32'h0000_0101, 32'h0,         32'h80AA_BBCC, 1, 1'b1, 32'hFFFF_FFBB, 1'b0};
        vecs[14] = '{2'b01, 3'b010, 5'd0,  1'b1, 32'h0000_0000, 32'h0,         32'h1111_2222, 1, 1'b0, 32'h0,         1'b0};

        repeat (3) @(negedge clk);
        chk("reset.phase_wb", {31'd0, phase_writeback}, 32'd0);
        chk("reset.retire", {31'd0, retire}, 32'd0);
        chk("reset.load_err", {31'd0, load_err}, 32'd0);
        chk("reset.rddata_wr", rddata_wr, 32'd0);
        chk("reset.rdsel_wr", {27'd0, rdsel_wr}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset.ready_after_release", {31'd0, wb_ready}, 32'd1);

        for (int i = 0; i < 15; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        // Reset while a load is outstanding; the late response must be dropped.
        @(negedge clk);
        wb_valid = 1'b1; wb_src = 2'b01; funct3 = 3'b010; rdsel_in = 5'd9; rd_we = 1'b1;
        alu_result = 32'h0000_0100;
        @(negedge clk);
        wb_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid.ready_waiting", {31'd0, wb_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid.ready_async", {31'd0, wb_ready}, 32'd1);
        chk("rst_mid.phase_wb", {31'd0, phase_writeback}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 32'hA5A5_A5A5;
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk("rst_mid.no_write", {31'd0, phase_writeback}, 32'd0);
        chk("rst_mid.no_retire", {31'd0, retire}, 32'd0);
        chk("rst_mid.ready_idle", {31'd0, wb_ready}, 32'd1);
        @(negedge clk);
        chk("rst_mid.no_write_late", {31'd0, phase_writeback}, 32'd0);
        chk("rst_mid.rddata_clear", rddata_wr, 32'd0);
        $display("txn rst_mid: reset during WAIT_LOAD, late mem_rvalid dropped");
        run_txn(vecs[0], "post_reset_alu");

        for (int i = 0; i < 40; i++) begin
            logic        m_wr;
            logic [31:0] m_data;
            logic        m_err;
            rv.src   = $urandom_range(0, 1) ? 2'b01 : 2'($urandom_range(0, 3));
            rv.f3    = 3'($urandom);
            rv.rd    = 5'($urandom);
            rv.we    = ($urandom_range(0, 3) != 0);
            rv.alu   = $urandom;
            rv.pc    = $urandom;
            rv.rdata = $urandom;
            rv.dly   = $urandom_range(0, 4);
            model(rv, m_wr, m_data, m_err);
            rv.exp_wr   = m_wr;
            rv.exp_data = m_data;
            rv.exp_err  = m_err;
            run_txn(rv, $sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
